// File: rtl/ldtu_data32_rx_align.sv
// rtl/ldtu_data32_rx_align.sv - 32-bit word aligner that locks onto an idle pattern
// Optional autonomous lock-loss detector enabled by defining LDTU_RX_LOSS_DET_EN.
module ldtu_data32_rx_align #(
   parameter int                  Nbits_32       = 32,
   parameter int                  LOCK_COUNT     = 4,
   parameter logic [Nbits_32-1:0] idle_patternEA = 32'hEAAAAAAA,
   parameter logic [Nbits_32-1:0] idle_pattern5A = 32'h5A5A5A5A
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                TEST_ENABLE,
   input  logic                RESYNC,
   input  logic                DIN_VALID,
   input  logic [Nbits_32-1:0] DIN,
   output logic [Nbits_32-1:0] DOUT,
   output logic                DOUT_VALID,
   output logic                IDLE_DET,
   output logic                LOCKED,
   output logic [4:0]          BIT_OFFSET,
   output logic                LOCK_LOST
);

   typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

   localparam logic [3:0] LC = 4'(LOCK_COUNT);
   localparam int         BW = $clog2(2*Nbits_32);

   state_t                r_state, w_state_nxt;
   logic [4:0]            r_offset, w_offset_nxt;
   logic [3:0]            r_cnt, w_cnt_nxt;
   logic [Nbits_32-1:0]   r_prev, r_dout;
   logic                  r_dout_valid, r_idle_det, r_te_q;
   logic                  w_dout_valid_nxt;
   logic [2*Nbits_32-1:0] w_cat;
   logic [BW-1:0]         w_base;
   logic [Nbits_32-1:0]   w_window, w_idle_ref;
   logic                  w_match, w_force, w_loss_hit;

   assign w_cat      = {DIN, r_prev};
   assign w_base     = {{(BW-5){1'b0}}, r_offset};
   assign w_window   = w_cat[w_base +: Nbits_32];
   assign w_idle_ref = TEST_ENABLE ? idle_pattern5A : idle_patternEA;
   assign w_match    = (w_window == w_idle_ref);
   // A test-mode flip changes the reference pattern, so the old alignment is void.
   assign w_force    = RESYNC | (TEST_ENABLE != r_te_q);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= S_SEARCH;
         r_offset <= 5'd0;
         r_cnt    <= 4'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_offset <= w_offset_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_offset_nxt     = r_offset;
      w_cnt_nxt        = r_cnt;
      w_dout_valid_nxt = 1'b0;
      if (DIN_VALID) begin
         case (r_state)
            S_SEARCH: begin
               if (w_match) begin
                  w_cnt_nxt   = 4'd1;
                  w_state_nxt = (LC == 4'd1) ? S_LOCKED : S_CHECK;
               end else begin
                  w_offset_nxt = r_offset + 5'd1;
               end
            end
            S_CHECK: begin
               if (w_match) begin
                  w_cnt_nxt = r_cnt + 4'd1;
                  if (r_cnt + 4'd1 == LC)
                     w_state_nxt = S_LOCKED;
               end else begin
                  w_state_nxt  = S_SEARCH;
                  w_cnt_nxt    = 4'd0;
                  w_offset_nxt = r_offset + 5'd1;
               end
            end
            S_LOCKED: begin
               if (w_loss_hit) begin
                  w_state_nxt  = S_SEARCH;
                  w_cnt_nxt    = 4'd0;
                  w_offset_nxt = r_offset + 5'd1;
               end else begin
                  w_dout_valid_nxt = !w_match;
               end
            end
            default: w_state_nxt = S_SEARCH;
         endcase
      end
      if (w_force) begin
         w_state_nxt      = S_SEARCH;
         w_cnt_nxt        = 4'd0;
         w_offset_nxt     = r_offset;
         w_dout_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_prev       <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_idle_det   <= 1'b0;
         r_te_q       <= 1'b0;
      end else begin
         r_te_q       <= TEST_ENABLE;
         r_dout_valid <= w_dout_valid_nxt;
         if (DIN_VALID) begin
            r_prev     <= DIN;
            r_dout     <= w_window;
            r_idle_det <= w_match;
         end else begin
            r_idle_det <= 1'b0;
         end
      end
   end

`ifdef LDTU_RX_LOSS_DET_EN
   logic [15:0] r_loss_cnt;
   logic        r_lock_lost;

   // Fires on the valid non-idle word that makes the run 65535 long.
   assign w_loss_hit = DIN_VALID && (r_state == S_LOCKED) && !w_match &&
                       !w_force && (r_loss_cnt == 16'hFFFE);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_loss_cnt  <= 16'd0;
         r_lock_lost <= 1'b0;
      end else begin
         r_lock_lost <= w_loss_hit;
         if (w_force || w_loss_hit || (r_state != S_LOCKED))
            r_loss_cnt <= 16'd0;
         else if (DIN_VALID)
            r_loss_cnt <= w_match ? 16'd0 : r_loss_cnt + 16'd1;
      end
   end

   assign LOCK_LOST = r_lock_lost;
`else
   assign w_loss_hit = 1'b0;
   assign LOCK_LOST  = 1'b0;
`endif

   assign DOUT       = r_dout;
   assign DOUT_VALID = r_dout_valid;
   assign IDLE_DET   = r_idle_det;
   assign LOCKED     = (r_state == S_LOCKED);
   assign BIT_OFFSET = r_offset;

endmodule
